// File: rtl/uart_piso.sv
// uart_piso: parallel-in, serial-out UART transmitter.
// Sends start bit, CHAR_W data bits LSB first, optional parity, then STOP_BITS stop bits.
// A one-word holding buffer lets the next frame start straight after the last stop bit.
module uart_piso #(
    parameter int unsigned DIVIDER   = 4096,
    parameter int unsigned CHAR_W    = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned COUNTER_W = $clog2(DIVIDER)
) (
    input  logic              clock_50M,
    input  logic              reset,
    input  logic [CHAR_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              uart_tx_pin,
    output logic              busy
);

    localparam int unsigned IDX_W = $clog2(CHAR_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CHAR_W-1:0]   buf_data;
    logic [CHAR_W-1:0]   buf_data_nxt;
    logic                buf_full;
    logic                buf_full_nxt;
    logic [CHAR_W-1:0]   shift_reg;
    logic [CHAR_W-1:0]   shift_nxt;
    logic [IDX_W-1:0]    bit_idx;
    logic [IDX_W-1:0]    idx_nxt;
    logic [COUNTER_W-1:0] cnt;
    logic [COUNTER_W-1:0] cnt_nxt;
    logic                stop_idx;
    logic                stop_nxt;
    logic                par_bit;
    logic                par_nxt;
    logic                pin_nxt;
    logic                busy_nxt;
    logic                bit_end;
    logic                load;

    // Buffer can take a word whenever it is empty and we are out of reset
    assign tx_ready = ~buf_full & ~reset;

    // State and datapath registers
    always_ff @(posedge clock_50M) begin
        if (reset) begin
            state       <= S_IDLE;
            buf_data    <= '0;
            buf_full    <= 1'b0;
            shift_reg   <= '0;
            bit_idx     <= '0;
            cnt         <= '0;
            stop_idx    <= 1'b0;
            par_bit     <= 1'b0;
            uart_tx_pin <= 1'b1;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            buf_data    <= buf_data_nxt;
            buf_full    <= buf_full_nxt;
            shift_reg   <= shift_nxt;
            bit_idx     <= idx_nxt;
            cnt         <= cnt_nxt;
            stop_idx    <= stop_nxt;
            par_bit     <= par_nxt;
            uart_tx_pin <= pin_nxt;
            busy        <= busy_nxt;
        end
    end

    // Next-state, buffer handshake and serial line value
    always_comb begin
        state_nxt    = state;
        buf_data_nxt = buf_data;
        buf_full_nxt = buf_full;
        shift_nxt    = shift_reg;
        idx_nxt      = bit_idx;
        cnt_nxt      = cnt;
        stop_nxt     = stop_idx;
        par_nxt      = par_bit;
        pin_nxt      = uart_tx_pin;
        load         = 1'b0;
        bit_end      = (cnt == COUNTER_W'(DIVIDER - 1));

        if (state != S_IDLE) begin
            cnt_nxt = bit_end ? '0 : cnt + COUNTER_W'(1);
        end

        case (state)
            S_IDLE: begin
                pin_nxt = 1'b1;
                if (buf_full) begin
                    load = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_nxt = S_DATA;
                    idx_nxt   = '0;
                    pin_nxt   = shift_reg[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx == IDX_W'(CHAR_W - 1)) begin
                        if (PARITY != 0) begin
                            state_nxt = S_PARITY;
                            pin_nxt   = par_bit;
                        end else begin
                            state_nxt = S_STOP;
                            stop_nxt  = 1'b0;
                            pin_nxt   = 1'b1;
                        end
                    end else begin
                        shift_nxt = shift_reg >> 1;
                        idx_nxt   = bit_idx + IDX_W'(1);
                        pin_nxt   = shift_reg[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_nxt = S_STOP;
                    stop_nxt  = 1'b0;
                    pin_nxt   = 1'b1;
                end
            end
            S_STOP: begin
                pin_nxt = 1'b1;
                if (bit_end) begin
                    if (stop_idx == 1'(STOP_BITS - 1)) begin
                        if (buf_full) begin
                            load = 1'b1;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end else begin
                        stop_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                pin_nxt   = 1'b1;
            end
        endcase

        // Move the buffered word into the shifter and begin a new frame
        if (load) begin
            state_nxt    = S_START;
            shift_nxt    = buf_data;
            buf_full_nxt = 1'b0;
            cnt_nxt      = '0;
            pin_nxt      = 1'b0;
            par_nxt      = (^buf_data) ^ (PARITY == 2);
        end

        // Accept only into an empty buffer, so a load and an accept never coincide
        if (tx_valid && tx_ready) begin
            buf_data_nxt = tx_data;
            buf_full_nxt = 1'b1;
        end

        busy_nxt = (state_nxt != S_IDLE);
    end

endmodule

// File: tb/tb_uart_piso.sv
// Testbench for uart_piso: four instances with different framing, a scoreboard of
// accepted words and a per-instance line monitor comparing every clock of each frame.
module tb_uart_piso;

    localparam int N = 4;

    typedef struct {
        logic [7:0] w;
        int         acc;
    } item_t;

    logic         clk = 1'b0;
    logic [N-1:0] rst;
    logic [N-1:0] rst_q;
    logic [N-1:0] valid;
    logic [N-1:0] ready;
    logic [N-1:0] pin;
    logic [N-1:0] busy;
    logic [7:0]   data [N];
    int           cyc = 0;
    int           n_chk = 0;
    int           n_fail = 0;

    item_t q0[$];
    item_t q1[$];
    item_t q2[$];
    item_t q3[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    uart_piso #(.DIVIDER(16), .CHAR_W(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clock_50M(clk), .reset(rst[0]), .tx_data(data[0]), .tx_valid(valid[0]),
        .tx_ready(ready[0]), .uart_tx_pin(pin[0]), .busy(busy[0]));
    uart_piso #(.DIVIDER(16), .CHAR_W(8), .PARITY(1), .STOP_BITS(1)) u1 (
        .clock_50M(clk), .reset(rst[1]), .tx_data(data[1]), .tx_valid(valid[1]),
        .tx_ready(ready[1]), .uart_tx_pin(pin[1]), .busy(busy[1]));
    uart_piso #(.DIVIDER(16), .CHAR_W(8), .PARITY(2), .STOP_BITS(2)) u2 (
        .clock_50M(clk), .reset(rst[2]), .tx_data(data[2]), .tx_valid(valid[2]),
        .tx_ready(ready[2]), .uart_tx_pin(pin[2]), .busy(busy[2]));
    uart_piso #(.DIVIDER(4096), .CHAR_W(8), .PARITY(0), .STOP_BITS(1)) u3 (
        .clock_50M(clk), .reset(rst[3]), .tx_data(data[3]), .tx_valid(valid[3]),
        .tx_ready(ready[3]), .uart_tx_pin(pin[3]), .busy(busy[3]));

    // Per-instance configuration
    function automatic int div_of(input int i);
        return (i == 3) ? 4096 : 16;
    endfunction
    function automatic int par_of(input int i);
        return (i == 1) ? 1 : (i == 2) ? 2 : 0;
    endfunction
    function automatic int stop_of(input int i);
        return (i == 2) ? 2 : 1;
    endfunction
    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Reference frame: bit b of the frame carrying word w
    function automatic int frame_bits(input int i);
        return 1 + 8 + ((par_of(i) != 0) ? 1 : 0) + stop_of(i);
    endfunction
    function automatic logic exp_bit(input int i, input logic [7:0] w, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return w[b-1];
        if (b == 9 && par_of(i) != 0) return (^w) ^ (par_of(i) == 2);
        return 1'b1;
    endfunction

    // Scoreboard queue access
    function automatic int q_size(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            2:       return q2.size();
            default: return q3.size();
        endcase
    endfunction
    function automatic item_t q_front(input int i);
        case (i)
            0:       return q0[0];
            1:       return q1[0];
            2:       return q2[0];
            default: return q3[0];
        endcase
    endfunction
    task automatic q_push(input int i, input item_t it);
        case (i)
            0:       q0.push_back(it);
            1:       q1.push_back(it);
            2:       q2.push_back(it);
            default: q3.push_back(it);
        endcase
    endtask
    task automatic q_pop(input int i, output item_t it);
        case (i)
            0:       it = q0.pop_front();
            1:       it = q1.pop_front();
            2:       it = q2.pop_front();
            default: it = q3.pop_front();
        endcase
    endtask
    task automatic q_flush(input int i);
        case (i)
            0:       q0.delete();
            1:       q1.delete();
            2:       q2.delete();
            default: q3.delete();
        endcase
    endtask

    task automatic chk1(input int i, input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL inst%0d %s: got %b expected %b at cycle %0d", i, name, act, exp, cyc);
        end
    endtask
    task automatic chk_int(input int i, input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL inst%0d %s: got %0d expected %0d at cycle %0d", i, name, act, exp, cyc);
        end
    endtask

    // Line monitor: checks idle line, frame start time, every bit clock, busy and tx_ready
    task automatic monitor(input int i);
        int    pos = -1;
        int    prev_end = 0;
        item_t cur;
        item_t it;
        cur.w = '0;
        cur.acc = 0;
        forever begin
            @(negedge clk);
            if (rst_q[i]) begin
                pos = -1;
                prev_end = 0;
                q_flush(i);
                chk1(i, "reset_pin", pin[i], 1'b1);
                chk1(i, "reset_busy", busy[i], 1'b0);
                chk1(i, "reset_ready", ready[i], !rst[i]);
                continue;
            end
            if (pos < 0) begin
                if (q_size(i) > 0) begin
                    it = q_front(i);
                    if (cyc > imax(it.acc + 1, prev_end)) begin
                        chk_int(i, "frame_missing_start", cyc, imax(it.acc + 1, prev_end));
                        q_pop(i, it);
                    end
                end
                if (pin[i] === 1'b0 && q_size(i) > 0) begin
                    q_pop(i, cur);
                    chk_int(i, "start_time", cyc, imax(cur.acc + 1, prev_end));
                    pos = 0;
                end else begin
                    chk1(i, "idle_pin", pin[i], 1'b1);
                    chk1(i, "idle_busy", busy[i], 1'b0);
                end
            end
            if (pos >= 0) begin
                chk1(i, "frame_pin", pin[i], exp_bit(i, cur.w, pos / div_of(i)));
                chk1(i, "frame_busy", busy[i], 1'b1);
                pos++;
                if (pos == div_of(i) * frame_bits(i)) begin
                    pos = -1;
                    prev_end = cyc + 1;
                end
            end
            chk1(i, "ready", ready[i], !rst[i] && q_size(i) == 0);
        end
    endtask

    for (genvar g = 0; g < N; g++) begin : g_mon
        initial monitor(g);
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Offer a word and hold it until accepted; returns one step after the accepting edge
    task automatic send(input int i, input logic [7:0] w);
        item_t it;
        bit    done = 1'b0;
        valid[i] = 1'b1;
        data[i]  = w;
        for (int t = 0; t < 3000 && !done; t++) begin
            if (ready[i]) begin
                it.w   = w;
                it.acc = cyc + 1;
                @(posedge clk);
                q_push(i, it);
                done = 1'b1;
                #1;
            end else begin
                align();
            end
        end
        if (!done) chk_int(i, "handshake_timeout", 0, 1);
    endtask

    task automatic release_valid(input int i);
        valid[i] = 1'b0;
        data[i]  = 8'($urandom);
    endtask

    // Wiggle tx_data with tx_valid low until the instance has drained
    task automatic wait_idle(input int i, input int bound);
        bit done = 1'b0;
        for (int t = 0; t < bound && !done; t++) begin
            data[i] = 8'($urandom);
            if (q_size(i) == 0 && busy[i] == 1'b0) done = 1'b1;
            else align();
        end
        if (!done) chk_int(i, "drain_timeout", 0, 1);
    endtask

    task automatic run_inst(input int i);
        int t0;
        align();
        case (i)
            0: begin
                send(0, 8'hA5); release_valid(0); wait_idle(0, 400);
                send(0, 8'h00); send(0, 8'hFF); release_valid(0); wait_idle(0, 800);
                for (int k = 0; k < 3; k++) send(0, 8'($urandom));
                release_valid(0); wait_idle(0, 1000);
                // Abort a frame during data bit 3 with the buffer full
                send(0, 8'h3C);
                t0 = cyc;
                send(0, 8'h99); release_valid(0);
                while (cyc < t0 + 1 + 72) align();
                rst[0] = 1'b1;
                repeat (3) align();
                rst[0] = 1'b0;
                for (int k = 0; k < 300; k++) begin
                    data[0] = 8'($urandom);
                    align();
                end
                send(0, 8'h81); release_valid(0); wait_idle(0, 400);
                for (int k = 0; k < 6; k++) begin
                    send(0, 8'($urandom));
                    if ($urandom_range(0, 1) == 1) begin
                        release_valid(0);
                        repeat ($urandom_range(1, 200)) align();
                    end
                end
                release_valid(0); wait_idle(0, 2000);
            end
            1, 2: begin
                send(i, 8'h07); release_valid(i); wait_idle(i, 400);
                for (int k = 0; k < 4; k++) send(i, 8'($urandom));
                release_valid(i); wait_idle(i, 1500);
            end
            default: begin
                send(3, 8'h55); release_valid(3); wait_idle(3, 50000);
            end
        endcase
    endtask

    initial begin
        rst   = '1;
        valid = '0;
        for (int i = 0; i < N; i++) data[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = '0;
        fork
            run_inst(0);
            run_inst(1);
            run_inst(2);
            run_inst(3);
        join
        repeat (5) align();
        for (int i = 0; i < N; i++) chk_int(i, "scoreboard_empty", q_size(i), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
